// File: rtl/regfile_mp.sv
// Multi-read-port register file with pending-write scoreboard and sequential bulk-clear engine.
// Latency: reads combinational (0 cycles); writes/pending visible next cycle; clear takes NUM_REGS+1 cycles.
// Backpressure: none; while busy, wren/iss_en/clr_req are dropped. Optional REGFILE_BYPASS_EN forwards wdat to reads.
module regfile_mp #(
   parameter int BITSIZE  = 16,
   parameter int ADDSIZE  = 4,
   parameter int NRD      = 2,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NRD*ADDSIZE-1:0] ra,
   output logic [NRD*BITSIZE-1:0] rdat,
   output logic [NRD-1:0]         rpend,
   input  logic [ADDSIZE-1:0]     rw,
   input  logic [BITSIZE-1:0]     wdat,
   input  logic                   wren,
   input  logic                   iss_en,
   input  logic [ADDSIZE-1:0]     iss_addr,
   output logic [2**ADDSIZE-1:0]  pend,
   input  logic                   clr_req,
   output logic                   busy,
   output logic                   clr_done
);

   localparam int NUM_REGS = 2**ADDSIZE;

   typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

   state_t               state;
   logic [ADDSIZE-1:0]   cnt;
   logic                 armed;
   logic [BITSIZE-1:0]   regs [NUM_REGS];
   logic                 wr_ok;
   logic                 iss_ok;
   logic                 clr_start;

   // Register 0 is never written or issued when hardwired, so it stays 0 and never pending.
   assign wr_ok     = wren   && !busy && !(ZERO_REG && (rw == '0));
   assign iss_ok    = iss_en && !busy && !(ZERO_REG && (iss_addr == '0));
   // armed drops whenever a request is seen, so a level held through DONE cannot retrigger.
   assign clr_start = (state == IDLE) && clr_req && armed;

   // Clear engine: walks cnt over every register, then pulses clr_done for one cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= '0;
         armed    <= 1'b1;
         busy     <= 1'b0;
         clr_done <= 1'b0;
      end else begin
         clr_done <= 1'b0;
         case (state)
            IDLE: begin
               armed <= ~clr_req;
               if (clr_start) begin
                  state <= CLEAR;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            CLEAR: begin
               armed <= 1'b0;
               cnt   <= cnt + ADDSIZE'(1);
               // cnt all-ones is the last register; the increment wraps it back to 0.
               if (cnt == '1) begin
                  state    <= DONE;
                  clr_done <= 1'b1;
               end
            end
            DONE: begin
               armed <= 1'b0;
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Storage and scoreboard: clear engine zeroes one register per cycle; issue beats write on the same address.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
         pend <= '0;
      end else begin
         if (state == CLEAR) begin
            regs[cnt] <= '0;
         end else if (wr_ok) begin
            regs[rw] <= wdat;
         end
         if (clr_start) begin
            pend <= '0;
         end else begin
            if (wr_ok) begin
               pend[rw] <= 1'b0;
            end
            if (iss_ok) begin
               pend[iss_addr] <= 1'b1;
            end
         end
      end
   end

   // Combinational read ports with optional same-cycle write forwarding.
   always_comb begin
      rdat  = '0;
      rpend = '0;
      for (int i = 0; i < NRD; i++) begin
         rdat[i*BITSIZE +: BITSIZE] = regs[ra[i*ADDSIZE +: ADDSIZE]];
         rpend[i]                   = pend[ra[i*ADDSIZE +: ADDSIZE]];
`ifdef REGFILE_BYPASS_EN
         if (wr_ok && (ra[i*ADDSIZE +: ADDSIZE] == rw)) begin
            rdat[i*BITSIZE +: BITSIZE] = wdat;
            rpend[i]                   = 1'b0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp with default parameters.
// Directed scenario tasks plus a randomized scoreboard run against a reference model.
// Inputs are driven 1ns after the rising edge; outputs are sampled mid-cycle.
module tb_regfile_mp;
   localparam int BW   = 16;
   localparam int AW   = 4;
   localparam int NR   = 2;
   localparam int NREG = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [NR*AW-1:0]  ra = '0;
   logic [NR*BW-1:0]  rdat;
   logic [NR-1:0]     rpend;
   logic [AW-1:0]     rw = '0;
   logic [BW-1:0]     wdat = '0;
   logic              wren = 1'b0;
   logic              iss_en = 1'b0;
   logic [AW-1:0]     iss_addr = '0;
   logic [NREG-1:0]   pend;
   logic              clr_req = 1'b0;
   logic              busy;
   logic              clr_done;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [BW-1:0]   d0;
      logic [BW-1:0]   d1;
      logic [NR-1:0]   rp;
      logic [NREG-1:0] pv;
   } exp_t;
   exp_t sbq[$];

   logic [BW-1:0]   mreg [NREG];
   logic [NREG-1:0] mpend;

   regfile_mp #(.BITSIZE(BW), .ADDSIZE(AW), .NRD(NR), .ZERO_REG(1'b1)) dut (
      .clk(clk), .rst(rst), .ra(ra), .rdat(rdat), .rpend(rpend),
      .rw(rw), .wdat(wdat), .wren(wren), .iss_en(iss_en), .iss_addr(iss_addr),
      .pend(pend), .clr_req(clr_req), .busy(busy), .clr_done(clr_done)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      errors++;
      $display("FAIL watchdog timeout");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [BW-1:0] d);
      tick();
      wren = 1'b1; rw = a; wdat = d;
      tick();
      wren = 1'b0;
   endtask

   task automatic iss(input logic [AW-1:0] a);
      tick();
      iss_en = 1'b1; iss_addr = a;
      tick();
      iss_en = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      ra = {4'd9, 4'd5};
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (clr_done !== 1'b0) begin errors++; $display("FAIL reset_clr_done got %b want 0", clr_done); end
      checks++; if (pend !== 16'h0000) begin errors++; $display("FAIL reset_pend got %h want 0000", pend); end
      checks++; if (rdat !== 32'h0) begin errors++; $display("FAIL reset_rdat got %h want 00000000", rdat); end
      rst = 1'b1;
   endtask

   task automatic test_write();
      wr(4'd5, 16'hBEEF);
      ra = {4'd5, 4'd5};
      #1;
      checks++; if (rdat[15:0] !== 16'hBEEF) begin errors++; $display("FAIL write_rd0 got %h want BEEF", rdat[15:0]); end
      checks++; if (rdat[31:16] !== 16'hBEEF) begin errors++; $display("FAIL write_rd1 got %h want BEEF", rdat[31:16]); end
      checks++; if (rpend !== 2'b00) begin errors++; $display("FAIL write_rpend got %b want 00", rpend); end
      wr(4'd0, 16'h1234);
      ra = {4'd0, 4'd0};
      #1;
      checks++; if (rdat[15:0] !== 16'h0000) begin errors++; $display("FAIL zero_reg got %h want 0000", rdat[15:0]); end
   endtask

   task automatic test_bypass();
      logic [BW-1:0] exp_b;
`ifdef REGFILE_BYPASS_EN
      exp_b = 16'h00A5;
`else
      exp_b = 16'h0000;
`endif
      tick();
      ra = {4'd0, 4'd3};
      wren = 1'b1; rw = 4'd3; wdat = 16'h00A5;
      #1;
      checks++; if (rdat[15:0] !== exp_b) begin errors++; $display("FAIL bypass_same got %h want %h", rdat[15:0], exp_b); end
      tick();
      wren = 1'b0;
      #1;
      checks++; if (rdat[15:0] !== 16'h00A5) begin errors++; $display("FAIL bypass_next got %h want 00A5", rdat[15:0]); end
   endtask

   task automatic test_scoreboard();
      iss(4'd7);
      ra = {4'd7, 4'd7};
      #1;
      checks++; if (pend[7] !== 1'b1) begin errors++; $display("FAIL sb_issue got %b want 1", pend[7]); end
      checks++; if (rpend !== 2'b11) begin errors++; $display("FAIL sb_rpend got %b want 11", rpend); end
      tick();
      ra = {4'd1, 4'd1};
      iss_en = 1'b1; iss_addr = 4'd7; wren = 1'b1; rw = 4'd7; wdat = 16'h0777;
      tick();
      iss_en = 1'b0; wren = 1'b0;
      ra = {4'd7, 4'd7};
      #1;
      checks++; if (pend[7] !== 1'b1) begin errors++; $display("FAIL sb_same_edge got %b want 1", pend[7]); end
      checks++; if (rdat[15:0] !== 16'h0777) begin errors++; $display("FAIL sb_same_edge_data got %h want 0777", rdat[15:0]); end
      wr(4'd7, 16'h0707);
      #1;
      checks++; if (pend[7] !== 1'b0) begin errors++; $display("FAIL sb_retire got %b want 0", pend[7]); end
      checks++; if (rpend !== 2'b00) begin errors++; $display("FAIL sb_retire_rpend got %b want 00", rpend); end
      iss(4'd0);
      #1;
      checks++; if (pend !== 16'h0000) begin errors++; $display("FAIL sb_zero_issue got %h want 0000", pend); end
   endtask

   task automatic test_clear();
      int busy_cnt = 0, done_cnt = 0, first_busy = 0, last_busy = 0, done_cyc = 0;
      for (int i = 1; i < NREG; i++) wr(4'(i), 16'h1000 | 16'(i));
      iss(4'd9);
      iss(4'd12);
      tick();
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      for (int cyc = 1; cyc <= 24; cyc++) begin
         if (busy === 1'b1) begin
            busy_cnt++;
            if (first_busy == 0) first_busy = cyc;
            last_busy = cyc;
         end
         if (clr_done === 1'b1) begin done_cnt++; done_cyc = cyc; end
         wren = (cyc == 10) || (cyc == 18);
         rw = (cyc == 10) ? 4'd2 : 4'd6;
         wdat = (cyc == 10) ? 16'hFFFF : 16'h0606;
         iss_en = (cyc == 10);
         iss_addr = 4'd4;
         clr_req = (cyc >= 14) && (cyc <= 22);
         if (cyc == 3) begin
            ra = {4'd0, 4'd15};
            #1;
            checks++; if (rdat[15:0] !== 16'h100F) begin errors++; $display("FAIL clr_read_busy got %h want 100F", rdat[15:0]); end
         end
         tick();
      end
      wren = 1'b0; iss_en = 1'b0; clr_req = 1'b0;
      checks++; if (busy_cnt != 17) begin errors++; $display("FAIL clr_busy_len got %0d want 17", busy_cnt); end
      checks++; if (first_busy != 1 || last_busy != 17) begin errors++; $display("FAIL clr_busy_span got %0d..%0d want 1..17", first_busy, last_busy); end
      checks++; if (done_cnt != 1 || done_cyc != 17) begin errors++; $display("FAIL clr_done_pulse got cnt %0d cyc %0d want 1 17", done_cnt, done_cyc); end
      for (int a = 0; a < NREG; a++) begin
         logic [BW-1:0] e;
         e = (a == 6) ? 16'h0606 : 16'h0000;
         ra = {4'(a), 4'(a)};
         #1;
         checks++; if (rdat[15:0] !== e) begin errors++; $display("FAIL clr_reg%0d got %h want %h", a, rdat[15:0], e); end
      end
      checks++; if (pend !== 16'h0000) begin errors++; $display("FAIL clr_pend got %h want 0000", pend); end
   endtask

   task automatic test_reset_midclear();
      bit fell = 1'b0;
      for (int i = 8; i < NREG; i++) wr(4'(i), 16'hA000 | 16'(i));
      iss(4'd10);
      tick();
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      repeat (6) tick();
      rst = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy); end
      checks++; if (clr_done !== 1'b0) begin errors++; $display("FAIL mid_clr_done got %b want 0", clr_done); end
      checks++; if (pend !== 16'h0000) begin errors++; $display("FAIL mid_pend got %h want 0000", pend); end
      for (int a = 8; a < NREG; a++) begin
         ra = {4'(a), 4'(a)};
         #1;
         checks++; if (rdat[15:0] !== 16'h0000) begin errors++; $display("FAIL mid_reg%0d got %h want 0000", a, rdat[15:0]); end
      end
      tick();
      rst = 1'b1;
      tick();
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_restart got %b want 1", busy); end
      for (int k = 0; k < 40 && !fell; k++) begin
         tick();
         if (busy === 1'b0) fell = 1'b1;
      end
      checks++; if (!fell) begin errors++; $display("FAIL mid_restart_end got busy %b want 0", busy); end
   endtask

   task automatic test_random();
      exp_t e, g;
      logic [AW-1:0] a0, a1;
      for (int i = 0; i < NREG; i++) mreg[i] = '0;
      mpend = '0;
      for (int n = 0; n < 3000; n++) begin
         tick();
         a0 = 4'($urandom()); a1 = 4'($urandom());
         ra = {a1, a0};
         rw = 4'($urandom()); wdat = 16'($urandom());
         wren = ($urandom_range(0, 1) == 1);
         iss_en = ($urandom_range(0, 9) < 3);
         iss_addr = 4'($urandom());
         e.d0 = mreg[a0]; e.d1 = mreg[a1];
         e.rp = {mpend[a1], mpend[a0]};
`ifdef REGFILE_BYPASS_EN
         if (wren && rw != 0 && a0 == rw) begin e.d0 = wdat; e.rp[0] = 1'b0; end
         if (wren && rw != 0 && a1 == rw) begin e.d1 = wdat; e.rp[1] = 1'b0; end
`endif
         e.pv = mpend;
         sbq.push_back(e);
         @(negedge clk);
         g = sbq.pop_front();
         checks++; if (rdat[15:0] !== g.d0) begin errors++; $display("FAIL rnd_rd0 n=%0d got %h want %h", n, rdat[15:0], g.d0); end
         checks++; if (rdat[31:16] !== g.d1) begin errors++; $display("FAIL rnd_rd1 n=%0d got %h want %h", n, rdat[31:16], g.d1); end
         checks++; if (rpend !== g.rp) begin errors++; $display("FAIL rnd_rpend n=%0d got %b want %b", n, rpend, g.rp); end
         checks++; if (pend !== g.pv) begin errors++; $display("FAIL rnd_pend n=%0d got %h want %h", n, pend, g.pv); end
         if (wren && rw != 0) begin mreg[rw] = wdat; mpend[rw] = 1'b0; end
         if (iss_en && iss_addr != 0) mpend[iss_addr] = 1'b1;
      end
      tick();
      wren = 1'b0; iss_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_write();
      test_bypass();
      test_scoreboard();
      test_clear();
      test_reset_midclear();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file with a pending-write scoreboard and a sequential bulk-clear engine, for the pipelined datapath. It extends the two-read-port register file to NRD read ports, hardwires register 0 to zero, and tracks in-flight writes so the hazard unit can stall. It also wipes all registers in NUM_REGS cycles on request.

## Interface
- BITSIZE, 16, data width per register
- ADDSIZE, 4, address width; NUM_REGS = 2**ADDSIZE
- NRD, 2, number of read ports (1..8)
- ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and is never pending
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- ra  in  NRD*ADDSIZE  read addresses; port i at [i*ADDSIZE +: ADDSIZE]
- rdat  out  NRD*BITSIZE  read data; port i at [i*BITSIZE +: BITSIZE]
- rpend  out  NRD  port i address currently pending
- rw  in  ADDSIZE  write address
- wdat  in  BITSIZE  write data
- wren  in  1  write enable; also clears pending bit of rw
- iss_en  in  1  issue: mark iss_addr pending
- iss_addr  in  ADDSIZE  destination of issued instruction
- pend  out  NUM_REGS  scoreboard bit vector
- clr_req  in  1  request bulk clear
- busy  out  1  clear engine active
- clr_done  out  1  one-cycle pulse at end of clear

## Operation
- Reads are combinational: rdat[i] = reg[ra[i]], and rpend[i] = pend[ra[i]].
- With ZERO_REG=1, address 0 returns 0 with rpend 0, and writes and issues to address 0 are dropped.
- Write: on an edge with wren=1 and busy=0, reg[rw] <= wdat and pend[rw] <= 0.
- Issue: on an edge with iss_en=1 and busy=0, pend[iss_addr] <= 1.
- When iss_en and wren hit the same address on the same edge, issue wins and pend stays 1 (a new producer is in flight).
- Clear FSM states are IDLE, CLEAR and DONE.
  - IDLE: clr_req=1 moves to CLEAR, sets cnt <= 0 and pend <= 0.
  - CLEAR: each cycle reg[cnt] <= 0 and cnt increments. At cnt = NUM_REGS-1 the FSM moves to DONE. cnt is ADDSIZE bits, so the wrap to 0 is the terminal point and there is no extra bit.
  - DONE: clr_done=1 for one cycle, then back to IDLE.
- busy = 1 in CLEAR and DONE. While busy:
  - wren, iss_en and clr_req are ignored.
  - Reads still return stored contents.
  - Bypass is disabled.
- Reset values: all registers 0, pend 0, FSM IDLE, cnt 0, busy 0, clr_done 0.
- Reset asserted mid-clear aborts the clear immediately and gives the reset values above.

## Timing
- Read latency is 0 cycles (combinational from ra).
- A write is visible on rdat the cycle after the wren edge, or in the same cycle when bypass is compiled in.
- Pending set or clear is visible on pend and rpend the cycle after the edge.
- clr_req sampled at edge T gives busy=1 from T+1 through T+NUM_REGS+1 inclusive (NUM_REGS+1 cycles). clr_done=1 only during cycle T+NUM_REGS+1.
- The first cycle after busy falls accepts wren and iss_en normally.
- A clr_req held high through DONE does not retrigger. It must be low in IDLE for one cycle before a new clear is accepted; the FSM is level-sampled with an edge qualifier registered in IDLE.

## Configuration
- REGFILE_BYPASS_EN defined: in the same cycle, if wren=1, busy=0 and ra[i]==rw (and rw≠0 when ZERO_REG=1), then rdat[i]=wdat and rpend[i]=0.
- REGFILE_BYPASS_EN undefined: rdat always reflects stored contents, and a same-cycle read returns the old value.

## Test plan
- Reset then write: deassert rst, write reg5=0xBEEF, read ra0=5 and ra1=5 next cycle -> both 0xBEEF, rpend=0. Write reg0=0x1234 -> reads 0 (ZERO_REG=1).
- Bypass: wren=1, rw=3, wdat=0x00A5, ra0=3 in the same cycle -> rdat0=0x00A5 with REGFILE_BYPASS_EN defined, 0x0000 without it.
- Scoreboard: iss_en to addr 7 -> pend[7]=1 next cycle. Same-edge iss_en=7 and wren rw=7 -> pend[7] stays 1. Later wren rw=7 alone -> pend[7]=0.
- Bulk clear (ADDSIZE=4): fill regs 1..15 with nonzero values, pulse clr_req -> busy high for exactly 17 cycles, clr_done pulses in the 17th, all reads 0, pend=0. A wren of 0xFFFF to reg 2 during busy leaves reg2=0.
- Reset mid-clear: assert rst at CLEAR cnt=6 -> busy=0, clr_done=0 and pend=0 immediately, all regs 0, FSM accepts a new clr_req after release.
- Parameter sweep: NRD=4, BITSIZE=32, ADDSIZE=5 with random reads, writes and issues checked against a reference model for 10k cycles -> zero mismatches.
